// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: picks the next obstacle from an 8-bit LFSR, waits a
// pause between obstacles, arms the chosen obstacle with a one-cycle start
// pulse, counts completed obstacles and declares a win or a loss.
//
// Handshake: done_out is a one-cycle start pulse, issued while the FSM sits
// in START. obstacle_done is a single-cycle completion pulse, honoured only
// in WAIT_DONE. collision is a level, sampled every cycle but acted upon only
// in WAIT_DONE. There is no back-pressure in either direction.
module obstacle_scheduler #(
  parameter int          NUM_OBSTACLES  = 4,
  parameter int          GAP_CYCLES     = 65000000,
  parameter int          TIMEOUT_CYCLES = 260000000,
  parameter int          ROUNDS_TO_WIN  = 10,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_on,
  input  logic       menu_on,
  input  logic       collision,
  input  logic       obstacle_done,
  output logic [3:0] selected,
  output logic       play_selected,
  output logic       done_out,
  output logic [7:0] round_count,
  output logic       game_won,
  output logic       game_over
);

  // One counter serves both the pause and the watchdog, so it is sized for
  // the larger of the two limits.
  localparam int MAX_COUNT = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    NUM_CODES    = 4'(NUM_OBSTACLES);
  localparam logic [7:0]    WIN_ROUNDS   = 8'(ROUNDS_TO_WIN);
  localparam bit            SINGLE_CODE  = (NUM_OBSTACLES == 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GAP       = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    WON       = 3'd4,
    LOST      = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [3:0]      prev_code;
  logic [7:0]      lfsr;
  logic            lfsr_fb;
  logic [3:0]      candidate;
  logic            candidate_ok;
  logic            abort;
  logic [7:0]      round_next;

  // Feedback for x^8 + x^6 + x^5 + x^4 + 1.
  assign lfsr_fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign candidate    = lfsr[3:0];
  // With a single code a repeat is unavoidable, so the no-repeat rule is
  // dropped rather than stalling in GAP forever.
  assign candidate_ok = (candidate < NUM_CODES) &&
                        (SINGLE_CODE || (candidate != prev_code));
  assign abort        = menu_on || !game_on;
  assign round_next   = round_count + 8'd1;

  // Free-running LFSR; it re-rolls every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  // Game sequencing FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      prev_code     <= 4'hF;
      selected      <= 4'd0;
      play_selected <= 1'b0;
      done_out      <= 1'b0;
      round_count   <= 8'd0;
      game_won      <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          play_selected <= 1'b0;
          if (game_on && !menu_on) begin
            state       <= GAP;
            count       <= '0;
            round_count <= 8'd0;
          end
        end

        GAP: begin
          if (abort) begin
            state         <= IDLE;
            count         <= '0;
            play_selected <= 1'b0;
          end else if ((count >= GAP_LAST) && candidate_ok) begin
            selected      <= candidate;
            prev_code     <= candidate;
            count         <= '0;
            state         <= START;
            done_out      <= 1'b1;
            play_selected <= 1'b1;
          end else if (count < GAP_LAST) begin
            count <= count + 1'b1;
          end
        end

        START: begin
          if (abort) begin
            state         <= IDLE;
            play_selected <= 1'b0;
          end else begin
            state <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (abort) begin
            state         <= IDLE;
            count         <= '0;
            play_selected <= 1'b0;
          end else if (collision) begin
            state         <= LOST;
            count         <= '0;
            play_selected <= 1'b0;
            game_over     <= 1'b1;
          end else if (obstacle_done || (count >= TIMEOUT_LAST)) begin
            round_count   <= round_next;
            count         <= '0;
            play_selected <= 1'b0;
            if (round_next == WIN_ROUNDS) begin
              state    <= WON;
              game_won <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        WON: begin
          play_selected <= 1'b0;
          if (menu_on) begin
            state    <= IDLE;
            game_won <= 1'b0;
          end
        end

        LOST: begin
          play_selected <= 1'b0;
          if (menu_on) begin
            state     <= IDLE;
            game_over <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          play_selected <= 1'b0;
        end
      endcase
    end
  end

endmodule
